// File: rtl/gcd_sched_pkg.sv
// gcd_sched_pkg: shared state encoding and default sizing for the GCD scheduler
package gcd_sched_pkg;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_WIDTH          = 16;
    localparam int DEF_TIMEOUT_CYCLES = 1024;
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;
endpackage

// File: rtl/gcd_scheduler_if.sv
// gcd_scheduler_if: requester, response and shared-GCD pins of the scheduler
interface gcd_scheduler_if import gcd_sched_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*WIDTH-1:0]   req_a;
    logic [NUM_REQ*WIDTH-1:0]   req_b;
    logic                       resp_valid;
    logic                       resp_ready;
    logic [$clog2(NUM_REQ)-1:0] resp_id;
    logic [WIDTH-1:0]           resp_gcd;
    logic                       resp_error;
    logic                       busy;
    logic [WIDTH-1:0]           gcd_value1;
    logic [WIDTH-1:0]           gcd_value2;
    logic                       gcd_loading;
    logic [WIDTH-1:0]           gcd_result;
    logic                       gcd_valid;
    modport master (
        output req_valid, req_a, req_b, resp_ready, gcd_result, gcd_valid,
        input  req_ready, resp_valid, resp_id, resp_gcd, resp_error, busy,
               gcd_value1, gcd_value2, gcd_loading
    );
    modport slave (
        input  req_valid, req_a, req_b, resp_ready, gcd_result, gcd_valid,
        output req_ready, resp_valid, resp_id, resp_gcd, resp_error, busy,
               gcd_value1, gcd_value2, gcd_loading
    );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or above ptr, with wrap
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    input  logic                       en,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx
);
    localparam int IW = $clog2(NUM_REQ);
    logic hit;
    // scanning from the farthest offset down lets the nearest request win
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % NUM_REQ]) begin
                hit = 1'b1;
                idx = IW'((int'(ptr) + k) % NUM_REQ);
            end
        end
        grant = (en && hit) ? {{(NUM_REQ-1){1'b0}}, 1'b1} << idx : '0;
    end
endmodule

// File: rtl/gcd_scheduler.sv
// gcd_scheduler: shares one GCD unit among requesters, bypassing zero operands.
// GCD_SCHED_TIMEOUT_EN adds a RUN watchdog that aborts with resp_error.
module gcd_scheduler import gcd_sched_pkg::*; #(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int WIDTH          = DEF_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input logic            clock,
    input logic            reset,
    gcd_scheduler_if.slave bus
);
    localparam int IW = $clog2(NUM_REQ);
    state_t           state, state_n;
    logic [IW-1:0]    ptr, id, idx;
    logic [WIDTH-1:0] a, b, res, a_sel, b_sel;
    logic [NUM_REQ-1:0] grant;
    logic             err, take, zero, expire;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .en    (state == IDLE && !reset),
        .grant (grant),
        .idx   (idx)
    );

    assign take  = |grant;
    assign a_sel = bus.req_a[idx*WIDTH +: WIDTH];
    assign b_sel = bus.req_b[idx*WIDTH +: WIDTH];
    assign zero  = a_sel == '0 || b_sel == '0;

`ifdef GCD_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign expire = state == RUN && !bus.gcd_valid && cnt == CW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clock)
        if (reset) cnt <= '0;
        else cnt <= state == RUN ? cnt + 1'b1 : '0;
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign expire = 1'b0;
`endif

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = take ? (zero ? RESP : LOAD) : IDLE;
            LOAD:    state_n = RUN;
            RUN:     state_n = (bus.gcd_valid || expire) ? RESP : RUN;
            RESP:    state_n = bus.resp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= '0;
            id    <= '0;
            a     <= '0;
            b     <= '0;
            res   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && take) begin
                a   <= a_sel;
                b   <= b_sel;
                id  <= idx;
                ptr <= idx == IW'(NUM_REQ - 1) ? '0 : idx + 1'b1;
                if (zero) res <= a_sel | b_sel;
            end
            if (state == RUN && bus.gcd_valid) res <= bus.gcd_result;
            else if (expire) begin
                res <= '0;
                err <= 1'b1;
            end
            if (state == RESP && bus.resp_ready) err <= 1'b0;
        end
    end

    assign bus.req_ready   = grant;
    assign bus.resp_valid  = state == RESP;
    assign bus.resp_id     = id;
    assign bus.resp_gcd    = res;
    assign bus.resp_error  = err;
    assign bus.busy        = state != IDLE;
    assign bus.gcd_loading = state == LOAD;
    assign bus.gcd_value1  = a;
    assign bus.gcd_value2  = b;
endmodule

// File: doc/gcd_scheduler.md
# gcd_scheduler

- Shares one `GCD` datapath instance between `NUM_REQ` requesters using round-robin arbitration.
- Sequences each job: operand load, iteration, result capture and response handshake.
- Resolves zero operands itself, because the `GCD` unit does not terminate when `value1 == 0` and `value2 != 0`.
- Sits between the requester-side logic and the shared `GCD` instance, and drives that instance's load/value pins.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 16: operand/result width; matches the `GCD` ports.
- `TIMEOUT_CYCLES`, 1024: RUN watchdog limit; used only with `GCD_SCHED_TIMEOUT_EN`.

Ports:
- `clock`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: per-requester job request.
- `req_ready`  out  NUM_REQ: one-hot grant; at most one bit high.
- `req_a`, `req_b`  in  NUM_REQ*WIDTH: flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `resp_valid`  out  1: result available.
- `resp_ready`  in  1: consumer accepts the result.
- `resp_id`  out  $clog2(NUM_REQ): index of the requester that owns the result.
- `resp_gcd`  out  WIDTH: result.
- `resp_error`  out  1: job aborted by the watchdog.
- `busy`  out  1: state != IDLE.
- `gcd_value1`, `gcd_value2`  out  WIDTH: drive the `GCD` `io_value1` / `io_value2`.
- `gcd_loading`  out  1: drives `GCD` `io_loadingValues`.
- `gcd_result`  in  WIDTH: from `GCD` `io_outputGCD`.
- `gcd_valid`  in  1: from `GCD` `io_outputValid`.

## Operation
States: IDLE, LOAD, RUN, RESP.

- **IDLE**
  - Round-robin arbiter selects among `req_valid`, searching from pointer `ptr` upward with wrap.
  - `req_ready[g]` is asserted combinationally in the same cycle; that is the transfer.
  - On transfer:
    - latch `a`, `b`, `id = g`;
    - set `ptr <= (g+1) mod NUM_REQ`.
  - Next state:
    - if `a == 0` or `b == 0`: `resp_gcd <= a | b` and go to RESP (bypass; `GCD` not used);
    - otherwise go to LOAD.
- **LOAD** (exactly 1 cycle)
  - `gcd_loading = 1`.
  - `gcd_value1 = a`, `gcd_value2 = b`.
  - Next state RUN.
- **RUN**
  - `gcd_loading = 0`.
  - `gcd_valid` is sampled every cycle. When it is 1: `resp_gcd <= gcd_result`, go to RESP.
  - `gcd_valid` is never sampled in IDLE or LOAD, so a stale `gcd_valid` from the previous job is ignored.
- **RESP**
  - `resp_valid = 1`; `resp_id`, `resp_gcd`, `resp_error` stay stable until `resp_ready`.
  - On `resp_valid && resp_ready`: go to IDLE.
  - A new grant can occur no earlier than the next cycle.
- `req_ready` is 0 in every state except IDLE.
- Requests never complete out of order; at most one job is in flight.
- Width rule: `resp_gcd` is `WIDTH` bits with no truncation; gcd(a,b) ≤ max(a,b).
- Outside LOAD, `gcd_value1` / `gcd_value2` hold the latched operands.

## Timing
- **Reset**: state IDLE, `ptr = 0`, latched operands 0. All outputs are 0: `req_ready`, `gcd_loading`, `gcd_value1/2`, `resp_valid`, `resp_id`, `resp_gcd`, `resp_error`, `busy`.
- **Reset mid-job**: the job is dropped with no response. The `GCD` instance needs no cleanup because the next LOAD overwrites it.
- **Grant at cycle t, nonzero operands**:
  - `gcd_loading` high in t+1;
  - first `gcd_valid` sample in t+2;
  - `resp_valid` rises the cycle after the first sampled `gcd_valid = 1`.
- **Bypass** (either operand zero): `resp_valid` high in t+1.
- **Simultaneous requests**: lowest index at or above `ptr` wins. Losers keep `req_valid` asserted with operands stable until granted.
- **`resp_ready` held low**: the block stalls in RESP indefinitely; no further grants.

## Configuration
Macro: `GCD_SCHED_TIMEOUT_EN`.
- **Defined**:
  - a RUN cycle counter is cleared on entry to RUN;
  - if it reaches `TIMEOUT_CYCLES` with `gcd_valid` still 0, the block sets `resp_gcd = 0`, `resp_error = 1` and goes to RESP;
  - `resp_error` clears on the response handshake.
- **Undefined**:
  - no counter;
  - `resp_error` is tied 0;
  - RUN waits on `gcd_valid` indefinitely.

## Structure
- **Package `gcd_sched_pkg`**:
  - state enum (IDLE/LOAD/RUN/RESP);
  - default `WIDTH`, `NUM_REQ`, `TIMEOUT_CYCLES` constants.
- **Sub-module `rr_arbiter`**:
  - parameter `NUM_REQ`;
  - inputs: request vector, pointer, enable;
  - outputs: one-hot grant and encoded index.
- The FSM, operand/result registers and the watchdog live in `gcd_scheduler`. The testbench instantiates `GCD` beside it.

## Test plan
- **Single job**: req0 a=12, b=18. Expect `gcd_loading` pulse 1 cycle after grant, then `resp_gcd = 6`, `resp_id = 0`, `resp_error = 0`.
- **Bypass**: req2 a=0, b=7 → `resp_gcd = 7`, `resp_valid` 1 cycle after grant, `gcd_loading` never asserted. Also a=9, b=0 → 9.
- **Round-robin fairness**: all 4 requesters held valid (operands 4,6 → 2) for 8 jobs. Expect grant order 0,1,2,3,0,1,2,3 and every `resp_gcd = 2`.
- **Backpressure**: `resp_ready` low for 10 cycles after `resp_valid`. Expect outputs stable, `req_ready` all 0, `busy = 1`; resume on `resp_ready = 1`.
- **Reset mid-RUN**: assert `reset` during RUN of a=1000, b=3. Next cycle all outputs are 0 and the state is IDLE; a new job a=8, b=12 then returns 4.
- **Watchdog** (`GCD_SCHED_TIMEOUT_EN`, `TIMEOUT_CYCLES = 16`): stub `gcd_valid` stuck 0. Expect `resp_error = 1` and `resp_gcd = 0` after 16 RUN cycles.
